// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter slice.
// Optional feature macro used by this slice: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Picks one of the fetch/data requesters; o_gnt is one-hot {dm, if}.
// MEM_ARB_ROUND_ROBIN_EN switches from fixed dm priority to alternating priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_if_req,
  input  logic       i_dm_req,
  input  logic       i_last_dm,
  output logic [1:0] o_gnt
);

  logic w_dm_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie the requester that was not granted last goes first.
  assign w_dm_wins = i_dm_req & (~i_if_req | ~i_last_dm);
`else
  logic w_unused_last;
  assign w_unused_last = i_last_dm;
  assign w_dm_wins     = i_dm_req;
`endif

  assign o_gnt = {w_dm_wins, i_if_req & ~w_dm_wins};

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between a fetch and a data requester.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternating tie-break priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_stall_o,
  output logic              dm_stall_o
);

  state_t            r_state;
  state_t            w_state_next;
  owner_t            r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_last_dm;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              w_complete;
  logic              w_can_grant;
  logic              w_gnt_if;
  logic              w_gnt_dm;
  logic [1:0]        w_pick;

  mem_arb_pick u_pick (
    .i_if_req  (if_req_i),
    .i_dm_req  (dm_req_i),
    .i_last_dm (r_last_dm),
    .o_gnt     (w_pick)
  );

  // A grant may also land in the completion cycle, giving back-to-back issue.
  always_comb begin
    w_state_next = r_state;
    w_complete   = (r_state == ST_BUSY) && (r_cnt == '0);
    w_can_grant  = rst_n && ((r_state == ST_IDLE) || w_complete);
    w_gnt_if     = w_can_grant & w_pick[0];
    w_gnt_dm     = w_can_grant & w_pick[1];
    if (w_gnt_if || w_gnt_dm) begin
      w_state_next = ST_BUSY;
    end else if (w_complete) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= OWN_NONE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_last_dm <= 1'b0;
    end else if (w_gnt_if || w_gnt_dm) begin
      r_owner   <= w_gnt_dm ? OWN_DM : OWN_IF;
      r_cnt     <= CNT_W'(MEM_LAT - 1);
      r_we      <= w_gnt_dm & dm_we_i;
      r_last_dm <= w_gnt_dm;
    end else if (w_complete) begin
      r_owner <= OWN_NONE;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Read data is held per requester until that requester's next read returns.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (if_rvalid_o) begin
        r_if_rdata <= mem_rdata_i;
      end
      if (dm_rvalid_o && !r_we) begin
        r_dm_rdata <= mem_rdata_i;
      end
    end
  end

  assign if_gnt_o    = w_gnt_if;
  assign dm_gnt_o    = w_gnt_dm;
  assign mem_en_o    = w_gnt_if | w_gnt_dm;
  assign mem_we_o    = w_gnt_dm & dm_we_i;
  assign mem_addr_o  = w_gnt_dm ? dm_addr_i : if_addr_i;
  assign mem_wdata_o = w_gnt_dm ? dm_wdata_i : '0;

  assign if_rvalid_o = w_complete && (r_owner == OWN_IF);
  assign dm_rvalid_o = w_complete && (r_owner == OWN_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : r_if_rdata;
  assign dm_rdata_o  = (dm_rvalid_o && !r_we) ? mem_rdata_i : r_dm_rdata;

  assign if_stall_o  = if_req_i & ~if_rvalid_o;
  assign dm_stall_o  = dm_req_i & ~dm_rvalid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ifReq, dmReq, dmWe;
  logic [31:0] ifAddr, dmAddr, dmWdata;
  logic        ifGnt, ifRvalid, dmGnt, dmRvalid, memEn, memWe, ifStall, dmStall;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;

  logic        lIfReq, lIfGnt, lIfRvalid, lDmGnt, lDmRvalid, lMemEn, lMemWe, lIfStall, lDmStall;
  logic [31:0] lIfAddr, lIfRdata, lDmRdata, lMemAddr, lMemWdata, lMemRdata;

  int compared = 0;
  int mismatched = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt), .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata),
    .dm_req_i(dmReq), .dm_we_i(dmWe), .dm_addr_i(dmAddr), .dm_wdata_i(dmWdata),
    .dm_gnt_o(dmGnt), .dm_rvalid_o(dmRvalid), .dm_rdata_o(dmRdata),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata), .if_stall_o(ifStall), .dm_stall_o(dmStall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dutL (
    .clk_i(clk), .rst_n(rst_n),
    .if_req_i(lIfReq), .if_addr_i(lIfAddr), .if_gnt_o(lIfGnt), .if_rvalid_o(lIfRvalid), .if_rdata_o(lIfRdata),
    .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
    .dm_gnt_o(lDmGnt), .dm_rvalid_o(lDmRvalid), .dm_rdata_o(lDmRdata),
    .mem_en_o(lMemEn), .mem_we_o(lMemWe), .mem_addr_o(lMemAddr), .mem_wdata_o(lMemWdata),
    .mem_rdata_i(lMemRdata), .if_stall_o(lIfStall), .dm_stall_o(lDmStall)
  );

  always #5 clk = ~clk;

  // Environment memory: writes land at the issue edge, reads come back LAT cycles later.
  logic [31:0] memArr [256];
  logic [31:0] pipe0, pipe1, pipeL;
  always @(posedge clk) begin
    if (memEn && memWe) memArr[memAddr[9:2]] <= memWdata;
    pipe0 <= (memEn && !memWe) ? memArr[memAddr[9:2]] : 32'h0BAD_F00D;
    pipe1 <= pipe0;
    pipeL <= lMemEn ? (lMemWe ? lMemWdata : memArr[lMemAddr[9:2]]) : 32'h0BAD_F00D;
  end
  assign memRdata  = pipe1;
  assign lMemRdata = pipeL;

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                               input logic dWe, input logic [31:0] dAddr, input logic [31:0] dData);
    ifReq = iReq; ifAddr = iAddr; dmReq = dReq; dmWe = dWe; dmAddr = dAddr; dmWdata = dData;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic        ifReq;
    logic        dmReq;
    logic        dmWe;
    logic [31:0] ifAddr;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic        expIfGnt;
    logic        expDmGnt;
    logic        expMemWe;
    logic [31:0] expMemAddr;
  } vec_t;

  vec_t        vecs [7];
  vec_t        tv;
  logic        expIf, expDm, expMemWe, lastDm, firstDm;
  logic [31:0] expMemAddr, expData, expData2, ifHeld, dmHeld;
  logic        ifPend, dmPend, rDmWe, ifGrantedPrev, dmGrantedPrev, busy, ownerDm, ownerWe;
  logic        expIfG, expDmG, expIfRv, expDmRv, dmWins;
  logic [31:0] rIfAddr, rDmAddr, rDmWdata, ownerData, selAddr;
  int          nextFree;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h100};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h000, 32'h104, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h104};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h000, 32'h108, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h108};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h110, 32'h10C, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 32'h10C};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h114, 32'h000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h000};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h118, 32'h000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h118};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h120, 32'h11C, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h11C};

    // Reset: grants blocked and outputs cleared even with both requests high.
    lIfReq = 1'b0; lIfAddr = 32'h0;
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_gnt", {ifGnt, dmGnt, memEn}, 3'b000);
    checkOutput("rst_rvalid", {ifRvalid, dmRvalid}, 2'b00);
    checkOutput("rst_if_rdata", ifRdata, 32'h0);
    checkOutput("rst_dm_rdata", dmRdata, 32'h0);
    checkOutput("rst_stall", {ifStall, dmStall}, 2'b11);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    ifHeld = 32'h0; dmHeld = 32'h0; lastDm = 1'b0;

    for (int v = 0; v < 7; v++) begin
      tv = vecs[v];
      expIf = tv.expIfGnt; expDm = tv.expDmGnt; expMemWe = tv.expMemWe; expMemAddr = tv.expMemAddr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (tv.ifReq && tv.dmReq) begin
        expDm = !lastDm; expIf = lastDm;
        expMemWe = expDm & tv.dmWe; expMemAddr = expDm ? tv.dmAddr : tv.ifAddr;
      end
`endif
      @(posedge clk); #1;
      applyStimulus(tv.ifReq, tv.ifAddr, tv.dmReq, tv.dmWe, tv.dmAddr, tv.dmWdata);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_gnt", v), {ifGnt, dmGnt}, {expIf, expDm});
      checkOutput($sformatf("vec%0d_mem_en", v), memEn, expIf | expDm);
      if (expIf || expDm) begin
        checkOutput($sformatf("vec%0d_mem_addr", v), memAddr, expMemAddr);
        checkOutput($sformatf("vec%0d_mem_we", v), memWe, expMemWe);
      end
      if (expMemWe) checkOutput($sformatf("vec%0d_mem_wdata", v), memWdata, tv.dmWdata);
      checkOutput($sformatf("vec%0d_stall", v), {ifStall, dmStall}, {tv.ifReq, tv.dmReq});
      expData = memArr[expMemAddr[9:2]];
      if (expDm) lastDm = 1'b1;
      else if (expIf) lastDm = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rvalid_t1", v), {ifRvalid, dmRvalid, memEn}, 3'b000);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rvalid_t2", v), {ifRvalid, dmRvalid}, {expIf, expDm});
      if (expIf) ifHeld = expData;
      if (expDm && !expMemWe) dmHeld = expData;
      checkOutput($sformatf("vec%0d_if_rdata", v), ifRdata, ifHeld);
      checkOutput($sformatf("vec%0d_dm_rdata", v), dmRdata, dmHeld);
    end

    // Data write of a known word, then the read that returns it.
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("pre_wr_gnt", dmGnt, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("rd40_gnt_t0", {dmGnt, memEn, memWe}, 3'b110);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd40_rvalid_t1", dmRvalid, 1'b0);
    @(negedge clk);
    checkOutput("rd40_rvalid_t2", dmRvalid, 1'b1);
    checkOutput("rd40_rdata_t2", dmRdata, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("rd40_rvalid_t3", dmRvalid, 1'b0);
    checkOutput("rd40_rdata_held", dmRdata, 32'hDEAD_BEEF);
    dmHeld = 32'hDEAD_BEEF;

    // Write leaves the data read register untouched.
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h55);
    @(negedge clk);
    checkOutput("wr10_issue", {dmGnt, memEn, memWe}, 3'b111);
    checkOutput("wr10_addr", memAddr, 32'h10);
    checkOutput("wr10_wdata", memWdata, 32'h55);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wr10_ack_t2", dmRvalid, 1'b1);
    checkOutput("wr10_rdata_kept", dmRdata, 32'hDEAD_BEEF);

    // Simultaneous requests, the loser is granted in the completion cycle.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    firstDm = 1'b0;
`else
    firstDm = 1'b1;
`endif
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    checkOutput("both_gnt_t0", {ifGnt, dmGnt}, {!firstDm, firstDm});
    expData = memArr[firstDm ? 8'h11 : 8'h08];
    @(posedge clk); #1;
    if (firstDm) dmReq = 1'b0;
    else ifReq = 1'b0;
    @(negedge clk);
    checkOutput("both_idle_t1", {ifGnt, dmGnt, memEn}, 3'b000);
    checkOutput("both_stall_t1", {ifStall, dmStall}, {firstDm, !firstDm});
    @(negedge clk);
    checkOutput("both_rvalid_t2", {ifRvalid, dmRvalid}, {!firstDm, firstDm});
    checkOutput("both_gnt_t2", {ifGnt, dmGnt}, {firstDm, !firstDm});
    checkOutput("both_addr_t2", memAddr, firstDm ? 32'h20 : 32'h44);
    if (firstDm) dmHeld = expData;
    else ifHeld = expData;
    checkOutput("both_if_rdata_t2", ifRdata, ifHeld);
    checkOutput("both_dm_rdata_t2", dmRdata, dmHeld);
    expData2 = memArr[firstDm ? 8'h08 : 8'h11];
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("both_rvalid_t3", {ifRvalid, dmRvalid}, 2'b00);
    @(negedge clk);
    checkOutput("both_rvalid_t4", {ifRvalid, dmRvalid}, {firstDm, !firstDm});
    if (firstDm) ifHeld = expData2;
    else dmHeld = expData2;
    checkOutput("both_if_rdata_t4", ifRdata, ifHeld);
    checkOutput("both_dm_rdata_t4", dmRdata, dmHeld);

    // Reset in the middle of an outstanding read drops it.
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("mid_rst_gnt", dmGnt, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    checkOutput("mid_rst_outs", {ifGnt, dmGnt, memEn, ifRvalid, dmRvalid}, 5'b0);
    checkOutput("mid_rst_rdata", {ifRdata, dmRdata}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_rst_no_rvalid", {ifRvalid, dmRvalid, memEn}, 3'b000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    ifHeld = 32'h0; dmHeld = 32'h0; lastDm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_quiet%0d", k), {ifRvalid, dmRvalid}, 2'b00);
    end
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("post_rst_gnt", {ifGnt, memEn, memAddr}, {1'b1, 1'b1, 32'h48});
    expData = memArr[8'h12];
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("post_rst_rvalid", ifRvalid, 1'b1);
    checkOutput("post_rst_rdata", ifRdata, expData);
    checkOutput("post_rst_dm_rdata", dmRdata, 32'h0);

    // Single-cycle latency: a held fetch request is granted every cycle.
    @(posedge clk); #1;
    lIfReq = 1'b1; lIfAddr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("lat1_gnt%0d", k), {lIfGnt, lMemEn, lMemWe}, 3'b110);
      checkOutput($sformatf("lat1_rvalid%0d", k), lIfRvalid, k > 0);
      checkOutput($sformatf("lat1_stall%0d", k), lIfStall, k == 0);
      if (k > 0) checkOutput($sformatf("lat1_rdata%0d", k), lIfRdata, expData);
      expData = memArr[lIfAddr[9:2]];
      @(posedge clk); #1;
      if (k < 3) lIfAddr = lIfAddr + 32'h4;
      else lIfReq = 1'b0;
    end
    @(negedge clk);
    checkOutput("lat1_t4", {lIfGnt, lIfRvalid}, 2'b01);
    checkOutput("lat1_rdata4", lIfRdata, expData);
    @(negedge clk);
    checkOutput("lat1_t5", {lIfRvalid, lDmGnt, lDmRvalid, lDmStall}, 4'b0);
    checkOutput("lat1_dm_rdata", lDmRdata, 32'h0);

    // Randomized traffic against a transaction-level model.
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ifHeld = 32'h0; dmHeld = 32'h0; lastDm = 1'b0; busy = 1'b0; nextFree = 0;
    ifPend = 1'b0; dmPend = 1'b0; ifGrantedPrev = 1'b0; dmGrantedPrev = 1'b0;
    ownerDm = 1'b0; ownerWe = 1'b0; ownerData = 32'h0;
    rIfAddr = 32'h0; rDmAddr = 32'h0; rDmWdata = 32'h0; rDmWe = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (ifGrantedPrev) ifPend = 1'b0;
      if (dmGrantedPrev) dmPend = 1'b0;
      if (!ifPend && $urandom_range(0, 99) < 55) begin
        ifPend = 1'b1; rIfAddr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!dmPend && $urandom_range(0, 99) < 55) begin
        dmPend = 1'b1; rDmAddr = 32'($urandom_range(0, 255)) << 2;
        rDmWe = 1'($urandom_range(0, 1)); rDmWdata = $urandom;
      end
      applyStimulus(ifPend, rIfAddr, dmPend, rDmWe, rDmAddr, rDmWdata);
      @(negedge clk);
      expIfRv = 1'b0; expDmRv = 1'b0; expIfG = 1'b0; expDmG = 1'b0;
      if (busy && cyc == nextFree) begin
        busy = 1'b0;
        if (ownerDm) begin
          expDmRv = 1'b1;
          if (!ownerWe) dmHeld = ownerData;
        end else begin
          expIfRv = 1'b1;
          ifHeld = ownerData;
        end
      end
      if (!busy && (ifPend || dmPend)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        dmWins = dmPend && (!ifPend || !lastDm);
`else
        dmWins = dmPend;
`endif
        expDmG = dmWins; expIfG = !dmWins;
        selAddr = dmWins ? rDmAddr : rIfAddr;
        busy = 1'b1; nextFree = cyc + LAT; lastDm = dmWins;
        ownerDm = dmWins; ownerWe = dmWins & rDmWe; ownerData = memArr[selAddr[9:2]];
      end
      checkOutput("rnd_gnt", {ifGnt, dmGnt}, {expIfG, expDmG});
      checkOutput("rnd_rvalid", {ifRvalid, dmRvalid}, {expIfRv, expDmRv});
      checkOutput("rnd_if_rdata", ifRdata, ifHeld);
      checkOutput("rnd_dm_rdata", dmRdata, dmHeld);
      checkOutput("rnd_mem_en", memEn, expIfG | expDmG);
      if (expIfG || expDmG) begin
        checkOutput("rnd_mem_addr", memAddr, selAddr);
        checkOutput("rnd_mem_we", memWe, ownerWe);
        if (ownerWe) checkOutput("rnd_mem_wdata", memWdata, rDmWdata);
      end
      checkOutput("rnd_stall", {ifStall, dmStall}, {ifPend & !expIfRv, dmPend & !expDmRv});
      ifGrantedPrev = expIfG; dmGrantedPrev = expDmG;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
